// File: rtl/inst_queue.sv
// Instruction queue between fetch and predecode: a circular buffer of fetch responses
// that tracks outstanding requests and discards responses belonging to a flushed path.
module inst_queue #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          refresh,
  input  logic          ec_bp_fail,
  input  logic          stall,
  output logic          if_req_ready,
  input  logic          if_req_fire,
  input  logic          if_valid,
  input  logic [31:0]   if_pc,
  input  logic [31:0]   if_inst,
  input  logic          if_addr_error,
  output logic          pd_empty,
  output logic [31:0]   pd_pc,
  output logic [31:0]   pd_pc_8,
  output logic [31:0]   pd_inst,
  output logic          pd_addr_error,
  output logic [CW-1:0] q_count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;

  // Entry layout: {addr_error, inst, pc}
  logic [64:0] mem [DEPTH];
  logic [64:0] head;

  logic        flush;
  logic        resp_ok;
  logic        fire_ok;
  logic        push;
  logic        pop;
  logic [CW:0] occupancy;

  always_comb begin
    flush     = refresh | ec_bp_fail;
    // A response with nothing outstanding is a protocol violation and is ignored.
    resp_ok   = if_valid && (inflight_q != '0);
    push      = resp_ok && (drop_q == '0) && !flush;
    pop       = (count_q != '0) && !stall && !flush;
    // Entries that will actually land in the queue: queued plus live in-flight.
    occupancy = {1'b0, count_q} + {1'b0, inflight_q} - {1'b0, drop_q};
    if_req_ready = !flush && (occupancy < (CW+1)'(DEPTH)) && (inflight_q < CW'(DEPTH));
    fire_ok   = if_req_fire && if_req_ready;
  end

  always_comb begin
    count_d    = count_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (flush) begin
      // Every request still outstanding now belongs to the dead path.
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      inflight_d = inflight_q - (resp_ok ? CW'(1) : CW'(0));
      drop_d     = inflight_q - (resp_ok ? CW'(1) : CW'(0));
    end else begin
      if (push && !pop)
        count_d = count_q + CW'(1);
      else if (pop && !push)
        count_d = count_q - CW'(1);
      if (fire_ok && !resp_ok)
        inflight_d = inflight_q + CW'(1);
      else if (resp_ok && !fire_ok)
        inflight_d = inflight_q - CW'(1);
      if (resp_ok && (drop_q != '0))
        drop_d = drop_q - CW'(1);
      if (push)
        wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)
        rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_q] <= {if_addr_error, if_inst, if_pc};
  end

  always_comb begin
    pd_empty      = (count_q == '0);
    head          = pd_empty ? 65'd0 : mem[rd_ptr_q];
    pd_pc         = head[31:0];
    pd_inst       = head[63:32];
    pd_addr_error = head[64];
    pd_pc_8       = pd_pc + 32'd8;
    q_count       = count_q;
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: a behavioural queue model acts as scoreboard,
// entries are pushed on accepted responses and compared against the head every cycle.
module tb_inst_queue;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          resetn;
  logic          refresh;
  logic          ec_bp_fail;
  logic          stall;
  logic          if_req_ready;
  logic          if_req_fire;
  logic          if_valid;
  logic [31:0]   if_pc;
  logic [31:0]   if_inst;
  logic          if_addr_error;
  logic          pd_empty;
  logic [31:0]   pd_pc;
  logic [31:0]   pd_pc_8;
  logic [31:0]   pd_inst;
  logic          pd_addr_error;
  logic [CW-1:0] q_count;

  inst_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .resetn(resetn), .refresh(refresh), .ec_bp_fail(ec_bp_fail),
    .stall(stall), .if_req_ready(if_req_ready), .if_req_fire(if_req_fire),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_addr_error(if_addr_error), .pd_empty(pd_empty), .pd_pc(pd_pc),
    .pd_pc_8(pd_pc_8), .pd_inst(pd_inst), .pd_addr_error(pd_addr_error),
    .q_count(q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } ent_t;

  ent_t sb[$];
  int   m_inflight;
  int   m_drop;
  int   errors;
  int   checks;
  logic [31:0] next_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return !(refresh || ec_bp_fail) && ((sb.size() + m_inflight - m_drop) < DEPTH)
           && (m_inflight < DEPTH);
  endfunction

  task automatic check_outputs();
    ent_t h;
    bit   e;
    e = (sb.size() == 0);
    h = e ? '0 : sb[0];
    chk("pd_empty", {31'd0, pd_empty}, {31'd0, e});
    chk("q_count", 32'(q_count), 32'(sb.size()));
    chk("if_req_ready", {31'd0, if_req_ready}, {31'd0, m_ready()});
    chk("pd_pc", pd_pc, h.pc);
    chk("pd_pc_8", pd_pc_8, h.pc + 32'd8);
    chk("pd_inst", pd_inst, h.inst);
    chk("pd_addr_error", {31'd0, pd_addr_error}, {31'd0, h.err});
  endtask

  // Predict what the queue does at the coming clock edge from the current inputs.
  task automatic model_update();
    bit   resp_ok;
    ent_t e;
    resp_ok = if_valid && (m_inflight > 0);
    if (refresh || ec_bp_fail) begin
      sb.delete();
      m_inflight = m_inflight - (resp_ok ? 1 : 0);
      m_drop     = m_inflight;
      $display("flush: drop=%0d", m_drop);
    end else begin
      if (sb.size() > 0 && !stall) begin
        e = sb.pop_front();
        $display("pop   pc=%h inst=%h err=%0d", e.pc, e.inst, e.err);
      end
      if (resp_ok) begin
        if (m_drop > 0) begin
          m_drop--;
          $display("drop  pc=%h", if_pc);
        end else begin
          sb.push_back('{pc: if_pc, inst: if_inst, err: if_addr_error});
          $display("push  pc=%h", if_pc);
        end
      end
      m_inflight = m_inflight + (if_req_fire ? 1 : 0) - (resp_ok ? 1 : 0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic v, input logic [31:0] pc, input logic e);
    if_req_fire   = f;
    if_valid      = v;
    if_pc         = pc;
    if_inst       = pc ^ 32'h1357_9BDF;
    if_addr_error = e;
  endtask

  task automatic model_reset();
    sb.delete();
    m_inflight = 0;
    m_drop     = 0;
  endtask

  initial begin
    errors = 0; checks = 0;
    model_reset();
    resetn = 1'b0; refresh = 1'b0; ec_bp_fail = 1'b0; stall = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    tick();                      // outputs while held in reset
    resetn = 1'b1;
    tick();

    // Three requests, three in-order responses, head follows one cycle later.
    repeat (3) begin drive(1'b1, 1'b0, 32'd0, 1'b0); tick(); end
    drive(1'b0, 1'b1, 32'hBFC0_0000, 1'b0); tick();
    drive(1'b0, 1'b1, 32'hBFC0_0004, 1'b0); tick();
    drive(1'b0, 1'b1, 32'hBFC0_0008, 1'b0); tick();
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    repeat (2) tick();

    // Fill while stalled: push+pop at DEPTH-1, then full with ready low.
    stall = 1'b1;
    next_pc = 32'h0000_1000;
    repeat (DEPTH) begin drive(1'b1, 1'b0, 32'd0, 1'b0); tick(); end
    repeat (DEPTH - 1) begin
      drive(1'b0, 1'b1, next_pc, 1'b0); next_pc += 4; tick();
    end
    stall = 1'b0;
    drive(1'b0, 1'b1, next_pc, 1'b0); next_pc += 4; tick();
    stall = 1'b1;
    drive(1'b1, 1'b0, 32'd0, 1'b0); tick();
    drive(1'b0, 1'b1, next_pc, 1'b0); next_pc += 4; tick();
    drive(1'b0, 1'b0, 32'd0, 1'b0); tick();
    stall = 1'b0;
    for (int i = 0; i < 24; i++) begin
      drive(m_ready(), m_inflight > 0, next_pc, i[2]);
      if (m_inflight > 0) next_pc += 4;
      tick();
    end
    while (m_inflight > 0) begin
      drive(1'b0, 1'b1, next_pc, 1'b0); next_pc += 4; tick();
    end
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    repeat (DEPTH + 1) tick();

    // Branch mispredict with 3 queued and 2 outstanding.
    stall = 1'b1;
    repeat (5) begin drive(1'b1, 1'b0, 32'd0, 1'b0); tick(); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'h0000_2000 + 32'(i * 4), 1'b0); tick();
    end
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    ec_bp_fail = 1'b1; tick();
    ec_bp_fail = 1'b0;
    drive(1'b1, 1'b1, 32'h0000_2DEA, 1'b0); tick();
    drive(1'b0, 1'b1, 32'h0000_2DEB, 1'b0); tick();
    drive(1'b0, 1'b1, 32'h0000_3000, 1'b1); tick();
    drive(1'b0, 1'b0, 32'd0, 1'b0); tick();
    stall = 1'b0;
    repeat (2) tick();

    // Refresh coincident with the only outstanding response.
    drive(1'b1, 1'b0, 32'd0, 1'b0); tick();
    refresh = 1'b1;
    drive(1'b0, 1'b1, 32'h0000_4000, 1'b0); tick();
    refresh = 1'b0;
    drive(1'b1, 1'b0, 32'd0, 1'b0); tick();
    drive(1'b0, 1'b1, 32'h0000_4004, 1'b0); tick();
    drive(1'b0, 1'b0, 32'd0, 1'b0); tick();

    // PC wrap of pd_pc_8 and address error propagation.
    drive(1'b1, 1'b0, 32'd0, 1'b0); tick();
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1); tick();
    drive(1'b0, 1'b0, 32'd0, 1'b0); repeat (2) tick();

    // Stray response with nothing outstanding.
    drive(1'b0, 1'b1, 32'h0000_5000, 1'b0); tick();
    drive(1'b0, 1'b0, 32'd0, 1'b0); tick();

    // Asynchronous reset mid-burst: 5 queued, 2 outstanding.
    stall = 1'b1;
    repeat (7) begin drive(1'b1, 1'b0, 32'd0, 1'b0); tick(); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 32'h0000_6000 + 32'(i * 4), 1'b0); tick();
    end
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    #1 resetn = 1'b0;
    model_reset();
    #1 check_outputs();
    @(posedge clk); #1;
    resetn = 1'b1;
    stall = 1'b0;
    drive(1'b0, 1'b1, 32'h0000_6014, 1'b0); tick();
    drive(1'b0, 1'b1, 32'h0000_6018, 1'b0); tick();
    drive(1'b1, 1'b0, 32'd0, 1'b0); tick();
    drive(1'b0, 1'b1, 32'h0000_7000, 1'b0); tick();
    drive(1'b0, 1'b0, 32'd0, 1'b0); repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DEPTH, 8, queue entries; power of two, 4..32.
REQ-002 Parameter CW, $clog2(DEPTH)+1, width of all internal counters.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 resetn  in  1  reset, asynchronous active-low.
REQ-005 refresh  in  1  exception/eret flush of fetch path.
REQ-006 ec_bp_fail  in  1  branch-mispredict flush of fetch path.
REQ-007 stall  in  1  downstream pd/id register holding; blocks pop.
REQ-008 if_req_ready  out  1  fetch may issue a new request this cycle.
REQ-009 if_req_fire  in  1  fetch issued a request this cycle; legal only when if_req_ready=1.
REQ-010 if_valid  in  1  one fetch response returns this cycle, in request order.
REQ-011 if_pc  in  32  PC of response.
REQ-012 if_inst  in  32  instruction word of response.
REQ-013 if_addr_error  in  1  response carries fetch address error.
REQ-014 pd_empty  out  1  no valid head entry.
REQ-015 pd_pc  out  32  head PC.
REQ-016 pd_pc_8  out  32  head PC + 8.
REQ-017 pd_inst  out  32  head instruction.
REQ-018 pd_addr_error  out  1  head address-error flag.
REQ-019 q_count  out  CW  number of valid entries (debug/perf).

Function
REQ-020 Storage: circular buffer of DEPTH entries {pc, inst, addr_error}; wr_ptr/rd_ptr log2(DEPTH) bits, wrap DEPTH-1 -> 0.
REQ-021 Head outputs combinational from rd_ptr entry; when pd_empty=1, pd_pc, pd_inst, pd_addr_error SHALL read 0 and pd_pc_8 SHALL read 8.
REQ-022 pd_pc_8 = pd_pc + 8, modulo 2^32 (0xFFFFFFFC -> 0x00000004).
REQ-023 pd_empty = (q_count == 0).
REQ-024 Pop = !pd_empty && !stall && !flush; rd_ptr advances one entry.
REQ-025 Counter inflight: +1 on if_req_fire, -1 on if_valid, net 0 when both.
REQ-026 Counter drop: number of outstanding requests belonging to a flushed path.
REQ-027 Response handling: if if_valid and drop>0, drop decrements and data is discarded; if if_valid and drop==0, data is pushed at wr_ptr.
REQ-028 Latency: pushed entry visible on pd_* the cycle after if_valid; no same-cycle bypass.
REQ-029 if_req_ready = !flush && (q_count + inflight - drop) < DEPTH && inflight < DEPTH; guarantees push never finds queue full.
REQ-030 Simultaneous push and pop: both occur, q_count unchanged, including when q_count==DEPTH-1 or DEPTH.
REQ-031 flush = refresh || ec_bp_fail; on flush, next cycle q_count=0, rd_ptr=wr_ptr=0, no pop this cycle.
REQ-032 On flush, drop <= inflight - (if_valid ? 1 : 0); inflight <= same value; response arriving in flush cycle discarded.
REQ-033 Flush while drop>0 already: drop recomputed per REQ-032 (all outstanding become stale).
REQ-034 if_valid with inflight==0 is a protocol violation; response ignored, counters unchanged.
REQ-035 q_count, inflight, drop never underflow or exceed DEPTH.

Reset
REQ-036 resetn=0 asynchronously forces q_count=0, inflight=0, drop=0, rd_ptr=wr_ptr=0; outputs pd_empty=1, pd_pc=0, pd_inst=0, pd_addr_error=0, pd_pc_8=8, if_req_ready=1 once resetn=1 and no flush.
REQ-037 Reset asserted mid-operation discards all entries and outstanding-request accounting; storage array contents need no reset.

Verification
REQ-038 Issue 3 requests, return PCs 0xBFC00000/04/08 with stall=0 -> pd_pc sequence 0xBFC00000,04,08 one cycle after each if_valid, pd_pc_8 = 0xBFC00008,0C,10, then pd_empty=1.
REQ-039 stall=1, push DEPTH responses -> q_count=8, if_req_ready=0; release stall with continuous push/pop -> q_count stays 8, order preserved, no loss.
REQ-040 2 requests outstanding, 3 entries queued, ec_bp_fail=1 one cycle -> next cycle pd_empty=1, drop=2; next 2 if_valid discarded, third request's response (issued after flush) appears on pd_pc.
REQ-041 refresh coincident with if_valid, inflight=1 -> response discarded, drop=0, inflight=0, queue empty.
REQ-042 Response PC 0xFFFFFFFC with if_addr_error=1 -> pd_addr_error=1, pd_pc_8=0x00000004.
REQ-043 resetn=0 asserted mid-burst with 5 entries, 2 outstanding -> immediately pd_empty=1, q_count=0; after release, stale responses ignored (inflight==0), if_req_ready=1.
